// File: rtl/cgol_engine.sv
// Game-of-Life generation engine: ping-pong grid banks, one row per clock,
// optional toroidal edges, run/step control and a row-scan display driver.
module cgol_engine #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int RBITS = 3,
   parameter int GBITS = 16
) (
   input  logic             ph1,
   input  logic             reset_n,
   input  logic             load_en,
   input  logic [RBITS-1:0] load_addr,
   input  logic [COLS-1:0]  load_data,
   input  logic             wrap,
   input  logic             step,
   input  logic             run,
   input  logic [RBITS-1:0] rd_addr,
   output logic [COLS-1:0]  rd_data,
   output logic             busy,
   output logic             done,
   output logic [GBITS-1:0] gen_count,
   output logic             stable,
   output logic             extinct,
   output logic [ROWS-1:0]  disp_row,
   output logic [COLS-1:0]  disp_col
);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SWAP} state_t;

   localparam logic [RBITS-1:0] LAST_ROW = RBITS'(ROWS - 1);
   localparam logic [RBITS:0]   ROWS_EXT = (RBITS + 1)'(ROWS);

   state_t           state_q;
   logic [RBITS-1:0] r_q;
   logic [RBITS-1:0] scan_q;
   logic             wrap_q;
   logic             diff_q;
   logic             cur_sel_q;
   logic [GBITS-1:0] gen_q;
   logic             stable_q;
   logic             done_q;
   logic             busy_q;
   logic [COLS-1:0]  bank_q [2][ROWS];

   logic [COLS-1:0]  cur_rows [ROWS];
   logic [COLS-1:0]  up_row, mid_row, dn_row, next_row_d, any_alive;
   logic [COLS+1:0]  up_ext, mid_ext, dn_ext;
   logic [RBITS-1:0] prev_idx, succ_idx;

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         assign cur_rows[gi] = cur_sel_q ? bank_q[1][gi] : bank_q[0][gi];
         assign disp_row[gi] = (scan_q == RBITS'(gi));
      end
   endgenerate

   // Neighbour rows; with wrap off the rows beyond the grid read as dead.
   always_comb begin
      prev_idx = (r_q == '0) ? LAST_ROW : r_q - 1'b1;
      succ_idx = (r_q == LAST_ROW) ? '0 : r_q + 1'b1;
      mid_row  = cur_rows[r_q];
      up_row   = (r_q == '0 && !wrap_q) ? '0 : cur_rows[prev_idx];
      dn_row   = (r_q == LAST_ROW && !wrap_q) ? '0 : cur_rows[succ_idx];
      // Bit 0 is column -1 and bit COLS+1 is column COLS.
      up_ext   = {wrap_q & up_row[0],  up_row,  wrap_q & up_row[COLS-1]};
      mid_ext  = {wrap_q & mid_row[0], mid_row, wrap_q & mid_row[COLS-1]};
      dn_ext   = {wrap_q & dn_row[0],  dn_row,  wrap_q & dn_row[COLS-1]};
   end

   generate
      for (gi = 0; gi < COLS; gi++) begin : g_cell
         logic [3:0] n;
         assign n = 4'(up_ext[gi]) + 4'(up_ext[gi+1]) + 4'(up_ext[gi+2])
                  + 4'(mid_ext[gi])                   + 4'(mid_ext[gi+2])
                  + 4'(dn_ext[gi]) + 4'(dn_ext[gi+1]) + 4'(dn_ext[gi+2]);
         assign next_row_d[gi] = (n == 4'd3) | (mid_row[gi] & (n == 4'd2));
      end
   endgenerate

   always_comb begin
      any_alive = '0;
      for (int i = 0; i < ROWS; i++) begin
         any_alive = any_alive | cur_rows[i];
      end
   end

   assign extinct   = ~|any_alive;
   assign rd_data   = ({1'b0, rd_addr} < ROWS_EXT) ? cur_rows[rd_addr] : '0;
   assign disp_col  = cur_rows[scan_q];
   assign busy      = busy_q;
   assign done      = done_q;
   assign gen_count = gen_q;
   assign stable    = stable_q;

   always_ff @(posedge ph1 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         scan_q    <= '0;
         wrap_q    <= 1'b0;
         diff_q    <= 1'b0;
         cur_sel_q <= 1'b0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         for (int i = 0; i < ROWS; i++) begin
            bank_q[0][i] <= '0;
            bank_q[1][i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         scan_q <= (scan_q == LAST_ROW) ? '0 : scan_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               if (load_en) begin
                  if ({1'b0, load_addr} < ROWS_EXT) begin
                     bank_q[cur_sel_q][load_addr] <= load_data;
                  end
               end else if (step || run) begin
                  state_q <= S_COMPUTE;
                  busy_q  <= 1'b1;
                  r_q     <= '0;
                  wrap_q  <= wrap;
                  diff_q  <= 1'b0;
               end
            end
            S_COMPUTE: begin
               bank_q[~cur_sel_q][r_q] <= next_row_d;
               diff_q <= diff_q | (next_row_d != mid_row);
               if (r_q == LAST_ROW) begin
                  state_q <= S_SWAP;
               end else begin
                  r_q <= r_q + 1'b1;
               end
            end
            S_SWAP: begin
               cur_sel_q <= ~cur_sel_q;
               gen_q     <= gen_q + 1'b1;
               stable_q  <= ~diff_q;
               done_q    <= 1'b1;
               if (run) begin
                  state_q <= S_COMPUTE;
                  r_q     <= '0;
                  wrap_q  <= wrap;
                  diff_q  <= 1'b0;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cgol_engine.sv
// Directed bench for cgol_engine: an 8x8 instance for the pattern tests and a
// 12x10 instance for free-run cadence and out-of-range addressing.
module tb_cgol_engine;

   logic        ph1 = 1'b0;
   logic        reset_n = 1'b1;
   logic        load_en = 1'b0, wrap = 1'b0, step = 1'b0, run = 1'b0;
   logic [2:0]  load_addr = '0, rd_addr = '0;
   logic [7:0]  load_data = '0;
   logic [7:0]  rd_data, disp_row, disp_col;
   logic        busy, done, stable, extinct;
   logic [15:0] gen_count;

   logic        load_en_b = 1'b0, wrap_b = 1'b0, step_b = 1'b0, run_b = 1'b0;
   logic [3:0]  load_addr_b = '0, rd_addr_b = '0;
   logic [9:0]  load_data_b = '0, rd_data_b, disp_col_b;
   logic [11:0] disp_row_b;
   logic        busy_b, done_b, stable_b, extinct_b;
   logic [15:0] gen_count_b;

   int n_cmp = 0;
   int n_err = 0;

   cgol_engine #(.ROWS(8), .COLS(8), .RBITS(3), .GBITS(16)) dut (
      .ph1(ph1), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .wrap(wrap), .step(step), .run(run),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .gen_count(gen_count), .stable(stable), .extinct(extinct),
      .disp_row(disp_row), .disp_col(disp_col)
   );

   cgol_engine #(.ROWS(12), .COLS(10), .RBITS(4), .GBITS(16)) dut_b (
      .ph1(ph1), .reset_n(reset_n), .load_en(load_en_b), .load_addr(load_addr_b),
      .load_data(load_data_b), .wrap(wrap_b), .step(step_b), .run(run_b),
      .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
      .gen_count(gen_count_b), .stable(stable_b), .extinct(extinct_b),
      .disp_row(disp_row_b), .disp_col(disp_col_b)
   );

   always #5 ph1 = ~ph1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %-18s got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %-18s = %0h", tag, got);
      end
   endtask

   task automatic chk_row(input string tag, input int a, input logic [7:0] exp);
      rd_addr = 3'(a);
      #1;
      chk(tag, rd_data, exp);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge ph1);
      reset_n = 1'b1;
   endtask

   task automatic load_row(input int a, input logic [7:0] d);
      load_en = 1'b1; load_addr = 3'(a); load_data = d;
      @(negedge ph1);
      load_en = 1'b0;
   endtask

   // One generation via a step pulse; optionally tries a load on the first busy cycle.
   task automatic step_gen(input logic w, input bit inject, output int busy_cnt);
      bit seen;
      seen = 1'b0;
      busy_cnt = 0;
      wrap = w; step = 1'b1;
      @(negedge ph1);
      step = 1'b0;
      if (inject) begin
         load_en = 1'b1; load_addr = 3'd5; load_data = 8'hFF;
      end
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         @(negedge ph1);
         load_en = 1'b0;
      end
      chk("done_pulse", 32'(seen), 32'd1);
   endtask

   // Free-run n generations, releasing run during the last one.
   task automatic run_gens(input logic w, input int n);
      int dones;
      int last;
      dones = 0;
      last = 0;
      wrap = w; run = 1'b1;
      for (int cyc = 1; cyc < n * 12 + 20 && dones < n; cyc++) begin
         @(negedge ph1);
         if (done) begin
            dones++;
            if (dones == 1) chk("run_busy_at_done", 32'(busy), 32'd1);
            if (dones == 2) chk("run_period", 32'(cyc - last), 32'd9);
            if (dones == n - 1) run = 1'b0;
            last = cyc;
         end
      end
      run = 1'b0;
      chk("run_done_count", 32'(dones), 32'(n));
      chk("run_idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int bc;
      int cyc;
      int dones;
      int last;
      bit differs;
      logic [7:0] glider [8];
      glider = '{8'h02, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset values, held asynchronously before any clock edge.
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gen", 32'(gen_count), 32'd0);
      chk("rst_stable", 32'(stable), 32'd0);
      chk("rst_extinct", 32'(extinct), 32'd1);
      chk("rst_disp_row", 32'(disp_row), 32'h01);
      chk("rst_disp_col", 32'(disp_col), 32'h00);
      chk("rst_rd_data", 32'(rd_data), 32'h00);
      chk("rst_b_extinct", 32'(extinct_b), 32'd1);
      @(negedge ph1);
      reset_n = 1'b1;
      #1 chk("scan_start", 32'(disp_row), 32'h01);
      @(negedge ph1);
      chk("scan_advance", 32'(disp_row), 32'h02);

      // 12x10 instance: ignored out-of-range load, then free-run cadence.
      load_en_b = 1'b1; load_addr_b = 4'd13; load_data_b = 10'h3FF;
      @(negedge ph1);
      load_addr_b = 4'd5; load_data_b = 10'h01C;
      @(negedge ph1);
      load_en_b = 1'b0;
      rd_addr_b = 4'd13; #1 chk("b_rd_oob", 32'(rd_data_b), 32'h0);
      rd_addr_b = 4'd1;  #1 chk("b_no_alias", 32'(rd_data_b), 32'h0);
      run_b = 1'b1;
      dones = 0; last = 0;
      for (cyc = 1; cyc < 80 && dones < 4; cyc++) begin
         @(negedge ph1);
         if (done_b) begin
            dones++;
            if (dones == 1) chk("b_busy_at_done", 32'(busy_b), 32'd1);
            if (dones == 2 || dones == 3) chk("b_period", 32'(cyc - last), 32'd13);
            if (dones == 3) run_b = 1'b0;
            if (dones == 4) chk("b_idle_after", 32'(busy_b), 32'd0);
            last = cyc;
         end
      end
      chk("b_done_count", 32'(dones), 32'd4);
      chk("b_gen", 32'(gen_count_b), 32'd4);
      rd_addr_b = 4'd5; #1 chk("b_row5", 32'(rd_data_b), 32'h01C);
      rd_addr_b = 4'd4; #1 chk("b_row4", 32'(rd_data_b), 32'h000);

      // Blinker, dead edges.
      @(negedge ph1);
      do_reset();
      load_row(3, 8'h1C);
      chk_row("load_visible", 3, 8'h1C);
      cyc = 0;
      while (disp_row != 8'h08 && cyc < 16) begin
         @(negedge ph1);
         cyc++;
      end
      chk("disp_col_row3", 32'(disp_col), 32'h1C);
      step_gen(1'b0, 1'b0, bc);
      chk("blink_busy_cycles", 32'(bc), 32'd9);
      chk("blink_busy_low", 32'(busy), 32'd0);
      chk_row("blink1_r2", 2, 8'h08);
      chk_row("blink1_r3", 3, 8'h08);
      chk_row("blink1_r4", 4, 8'h08);
      chk_row("blink1_r5", 5, 8'h00);
      chk("blink1_gen", 32'(gen_count), 32'd1);
      chk("blink1_stable", 32'(stable), 32'd0);
      @(negedge ph1);
      chk("done_one_cycle", 32'(done), 32'd0);
      step_gen(1'b0, 1'b0, bc);
      chk_row("blink2_r2", 2, 8'h00);
      chk_row("blink2_r3", 3, 8'h1C);
      chk("blink2_gen", 32'(gen_count), 32'd2);

      // Block still life.
      do_reset();
      load_row(0, 8'h03);
      load_row(1, 8'h03);
      step_gen(1'b0, 1'b0, bc);
      chk_row("block_r0", 0, 8'h03);
      chk_row("block_r1", 1, 8'h03);
      chk_row("block_r2", 2, 8'h00);
      chk("block_stable", 32'(stable), 32'd1);
      chk("block_extinct", 32'(extinct), 32'd0);

      // Glider on the torus returns home after 32 generations.
      do_reset();
      for (int i = 0; i < 3; i++) load_row(i, glider[i]);
      run_gens(1'b1, 32);
      chk("glider_gen", 32'(gen_count), 32'd32);
      for (int i = 0; i < 8; i++) chk_row($sformatf("glider_r%0d", i), i, glider[i]);

      // Same glider with dead edges does not come back.
      do_reset();
      for (int i = 0; i < 3; i++) load_row(i, glider[i]);
      run_gens(1'b0, 32);
      differs = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1 if (rd_data != glider[i]) differs = 1'b1;
      end
      chk("glider_nowrap_diff", 32'(differs), 32'd1);

      // Lone cell dies, then the empty grid is stable.
      do_reset();
      load_row(4, 8'h10);
      step_gen(1'b0, 1'b0, bc);
      chk("single_extinct", 32'(extinct), 32'd1);
      chk("single_stable", 32'(stable), 32'd0);
      step_gen(1'b0, 1'b0, bc);
      chk("empty_stable", 32'(stable), 32'd1);
      chk("empty_gen", 32'(gen_count), 32'd2);

      // Load wins over step in the same IDLE cycle.
      do_reset();
      load_en = 1'b1; load_addr = 3'd2; load_data = 8'hFF; step = 1'b1;
      @(negedge ph1);
      load_en = 1'b0; step = 1'b0;
      chk("prio_busy", 32'(busy), 32'd0);
      @(negedge ph1);
      chk("prio_busy_later", 32'(busy), 32'd0);
      chk_row("prio_row2", 2, 8'hFF);

      // Load attempted during COMPUTE leaves the bank alone.
      step_gen(1'b0, 1'b1, bc);
      chk_row("line_r1", 1, 8'h7E);
      chk_row("line_r2", 2, 8'h7E);
      chk_row("line_r3", 3, 8'h7E);
      chk_row("line_r4", 4, 8'h00);
      chk_row("line_r5", 5, 8'h00);

      // Reset asserted at COMPUTE r=4 of the second free-run generation.
      do_reset();
      load_row(3, 8'h1C);
      wrap = 1'b0; run = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge ph1);
         if (done) break;
      end
      chk("prerst_gen", 32'(gen_count), 32'd1);
      repeat (4) @(negedge ph1);
      chk("prerst_busy", 32'(busy), 32'd1);
      reset_n = 1'b0; run = 1'b0; rd_addr = 3'd2;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_gen", 32'(gen_count), 32'd0);
      chk("midrst_disp_row", 32'(disp_row), 32'h01);
      chk("midrst_disp_col", 32'(disp_col), 32'h00);
      chk("midrst_extinct", 32'(extinct), 32'd1);
      chk("midrst_rd_data", 32'(rd_data), 32'h00);
      @(negedge ph1);
      reset_n = 1'b1;
      @(negedge ph1);
      for (int i = 0; i < 8; i++) chk_row($sformatf("postrst_r%0d", i), i, 8'h00);
      chk("postrst_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
